key_debounce: RTL and testbench

Single-channel mechanical-key receiver: synchronises a raw, bouncing, active-low key line into the clock domain, filters contact bounce with a counter-based state machine and emits a clean debounced level plus one-cycle press/release event pulses. It sits between the board key pins (or the bouncing key stimulus model in simulation) and consumer logic such as LED/mode controllers. One instance is used per key.

---
 rtl/key_debounce_pkg.sv | 24 ++
 rtl/key_debounce_sync.sv | 40 ++++
 rtl/key_debounce.sv | 122 ++++++++++++
 tb/tb_key_debounce.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_debounce_pkg
//  Purpose  : Shared FSM encodings, counter widths and 50 MHz default timing
//             for the key debounce receiver.
//  Revision : 1.0  initial release
// ============================================================================
package key_debounce_pkg;

    localparam int unsigned C_CNT_W        = 24;
    localparam int unsigned C_LONG_W       = 26;
    localparam int unsigned C_CNT_MAX_DEF  = 1_000_000;   // 20 ms at 50 MHz
    localparam int unsigned C_LONG_MAX_DEF = 50_000_000;  // 1 s at 50 MHz

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILT0 = 2'd1,
        S_DOWN  = 2'd2,
        S_FILT1 = 2'd3
    } key_fsm_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_sync
//  Purpose  : Two-flop synchroniser plus history flop for a raw key line;
//             reports the synchronised level and its falling/rising edges.
//  Revision : 1.0  initial release
// ============================================================================
module key_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic key_sync_lvl,
    output logic nedge,
    output logic pedge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Reset to the released level so no spurious edge appears after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign key_sync_lvl = r_s2;
    assign nedge        = r_s3 & ~r_s2;
    assign pedge        = ~r_s3 & r_s2;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Counter-based bounce filter for one active-low key; emits a
//             debounced level and one-cycle press/release pulses.
//             Define KEY_LONG_PRESS_EN to enable the key_long pulse.
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX  = C_CNT_MAX_DEF,
    parameter int unsigned LONG_MAX = C_LONG_MAX_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic key_state,
    output logic key_flag,
    output logic key_long
);

    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CNT_MAX - 1);

    logic               w_sync_lvl;
    logic               w_nedge;
    logic               w_pedge;
    key_fsm_t           r_state;
    logic [C_CNT_W-1:0] r_cnt;

    key_sync u_key_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_in       (key_in),
        .key_sync_lvl (w_sync_lvl),
        .nedge        (w_nedge),
        .pedge        (w_pedge)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            key_state <= 1'b1;
            key_flag  <= 1'b0;
        end else begin
            key_flag <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_nedge) r_state <= S_FILT0;
                end
                S_FILT0: begin
                    // An opposite edge always wins over a terminal count.
                    if (w_pedge) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_CNT_LAST && !w_sync_lvl) begin
                        r_state   <= S_DOWN;
                        key_flag  <= 1'b1;
                        key_state <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    r_cnt <= '0;
                    if (w_pedge) r_state <= S_FILT1;
                end
                S_FILT1: begin
                    if (w_nedge) begin
                        r_state <= S_DOWN;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_CNT_LAST && w_sync_lvl) begin
                        r_state   <= S_IDLE;
                        key_flag  <= 1'b1;
                        key_state <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam logic [C_LONG_W-1:0] C_LONG_LAST = C_LONG_W'(LONG_MAX - 1);

    logic [C_LONG_W-1:0] r_lcnt;

    // Saturates one past the threshold so each press yields a single pulse;
    // release bounces (FILT1) keep the count instead of restarting it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lcnt   <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= 1'b0;
            case (r_state)
                S_DOWN: begin
                    if (r_lcnt == C_LONG_LAST) begin
                        key_long <= 1'b1;
                        r_lcnt   <= r_lcnt + 1'b1;
                    end else if (r_lcnt < C_LONG_LAST) begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                S_FILT1: r_lcnt <= r_lcnt;
                default: r_lcnt <= '0;
            endcase
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_key_debounce
//  Purpose  : Scoreboard bench for key_debounce with CNT_MAX=100, LONG_MAX=500.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_debounce;

    localparam int CNT_MAX  = 100;
    localparam int LONG_MAX = 500;
    localparam int LAT      = CNT_MAX + 2;   // first sampling edge -> flag edge

    typedef struct {
        int   cycle;
        logic level;
    } flag_exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic key_in  = 1'b1;
    logic key_state;
    logic key_flag;
    logic key_long;

    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;
    flag_exp_t flag_q[$];
    int        long_q[$];

    key_debounce #(
        .CNT_MAX  (CNT_MAX),
        .LONG_MAX (LONG_MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_in    (key_in),
        .key_state (key_state),
        .key_flag  (key_flag),
        .key_long  (key_long)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected flag lands LAT edges after the next sampling edge.
    task automatic expect_flag(input logic level, input bit long_too);
        flag_exp_t e;
        e.cycle = cyc + 1 + LAT;
        e.level = level;
        flag_q.push_back(e);
`ifdef KEY_LONG_PRESS_EN
        if (long_too) long_q.push_back(e.cycle + LONG_MAX);
`else
        if (long_too) long_q.push_back(-1);
`endif
    endtask

    task automatic hold(input logic v, input int len);
        key_in = v;
        repeat (len) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses an output.
    always @(negedge clk) begin : monitor
        flag_exp_t e;
        int        lc;
        if (reset_n) begin
            if (key_flag) begin
                if (flag_q.size() == 0) begin
                    check("unexpected_flag", cyc, -1);
                end else begin
                    e = flag_q.pop_front();
                    check("flag_cycle", cyc, e.cycle);
                    check("flag_level", int'(key_state), int'(e.level));
                end
            end
            if (key_long) begin
                if (long_q.size() == 0) begin
                    check("unexpected_long", cyc, -1);
                end else begin
                    lc = long_q.pop_front();
                    check("long_cycle", cyc, lc);
                end
            end
        end
    end

    initial begin
        int bp[10] = '{20, 15, 30, 10, 40, 25, 35, 12, 18, 30};
        int br[10] = '{15, 10, 25, 20, 30, 12, 20, 15, 10, 25};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", int'(key_state), 1);
        check("rst_flag", int'(key_flag), 0);
        check("rst_long", int'(key_long), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_state", int'(key_state), 1);
        end

        // Clean press and release
        expect_flag(1'b0, 1'b0);
        hold(1'b0, 300);
        check("clean_press_state", int'(key_state), 0);
        expect_flag(1'b1, 1'b0);
        hold(1'b1, 300);
        check("clean_release_state", int'(key_state), 1);

        // Bouncy press: five low/high bursts, all shorter than the window
        for (int i = 0; i < 10; i++) hold(i % 2 == 0 ? 1'b0 : 1'b1, bp[i]);
        check("bounce_press_idle", int'(key_state), 1);
        expect_flag(1'b0, 1'b0);
        hold(1'b0, 300);
        check("bounce_press_state", int'(key_state), 0);

        // Bouncy release
        for (int i = 0; i < 10; i++) hold(i % 2 == 0 ? 1'b1 : 1'b0, br[i]);
        check("bounce_release_down", int'(key_state), 0);
        expect_flag(1'b1, 1'b0);
        hold(1'b1, 300);
        check("bounce_release_state", int'(key_state), 1);

        // Glitch, then the window boundary: 100 cycles rejected, 101 accepted
        hold(1'b0, 60);
        hold(1'b1, 200);
        check("glitch_state", int'(key_state), 1);
        hold(1'b0, 100);
        hold(1'b1, 200);
        check("edge100_state", int'(key_state), 1);
        expect_flag(1'b0, 1'b0);
        hold(1'b0, 101);
        expect_flag(1'b1, 1'b0);
        hold(1'b1, 300);
        check("edge101_state", int'(key_state), 1);

        // Long hold
`ifdef KEY_LONG_PRESS_EN
        expect_flag(1'b0, 1'b1);
`else
        expect_flag(1'b0, 1'b0);
`endif
        hold(1'b0, 800);
        check("long_hold_state", int'(key_state), 0);
        expect_flag(1'b1, 1'b0);
        hold(1'b1, 300);

        // Reset mid press filter: outputs clear at once, no flag later
        hold(1'b0, 50);
        reset_n = 1'b0;
        #1;
        check("midrst_state", int'(key_state), 1);
        check("midrst_flag", int'(key_flag), 0);
        check("midrst_long", int'(key_long), 0);
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        hold(1'b1, 200);
        check("post_rst_state", int'(key_state), 1);

        check("flag_queue_left", flag_q.size(), 0);
        check("long_queue_left", long_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
